vde_cmd_queue: RTL and testbench

VDE_CMD_QUEUE -- requirements
Module: vde_cmd_queue

---
 rtl/vde_cmd_queue.sv | 241 ++++++++++++++++++++++++
 tb/tb_vde_cmd_queue.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vde_cmd_queue.sv
// Command front end for the VSIDS heap: per-channel FIFOs, round-robin arbiter,
// multi-bump serializer and coalesced decay. Statistics exist only with VDE_CMDQ_STATS_EN.
//
// serializer state | meaning
// S_IDLE           | capture register free, bump_ready high (unless flushing)
// S_EMIT           | captured lanes pending, one h_op=10 per free issue slot

module vde_cmd_queue #(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 16,
  parameter int VAR_W    = 32,
  parameter int MAX_BUMP = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [2*NUM_CH-1:0]          in_op,
  input  logic [VAR_W*NUM_CH-1:0]      in_var,
  input  logic [NUM_CH-1:0]            in_val,
  input  logic [3:0]                   bump_count,
  input  logic [VAR_W*MAX_BUMP-1:0]    bump_vars,
  output logic                         bump_ready,
  input  logic                         decay,
  input  logic                         h_busy,
  output logic                         h_op_valid,
  output logic [1:0]                   h_op,
  output logic [VAR_W-1:0]             h_var,
  output logic                         h_val,
  output logic                         h_decay,
  output logic                         pending_ops,
  output logic [31:0]                  stat_issued,
  output logic [$clog2(DEPTH+1)-1:0]   stat_hwm
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int RW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW   = $clog2(MAX_BUMP+1);

  typedef enum logic {S_IDLE, S_EMIT} ser_state_t;

  logic [1:0]       mem_op  [NUM_CH][DEPTH];
  logic [VAR_W-1:0] mem_var [NUM_CH][DEPTH];
  logic             mem_val [NUM_CH][DEPTH];
  logic [PW-1:0]    wr_ptr  [NUM_CH];
  logic [PW-1:0]    rd_ptr  [NUM_CH];
  logic [CNTW-1:0]  count   [NUM_CH];
  logic [CNTW-1:0]  count_n [NUM_CH];

  logic [NUM_CH-1:0] nonempty, full, push, store, grant;
  logic [RW-1:0]     rr_ptr, rr_ptr_n;
  logic              found;
  logic              issue_en;
  logic              ser_issue, decay_issue;
  logic              decay_flag;
  logic              capture;

  ser_state_t                      ser_state, ser_state_n;
  logic [MAX_BUMP-1:0][VAR_W-1:0]  ser_vars, ser_vars_n;
  logic [CW-1:0]                   ser_left, ser_left_n;

  assign issue_en = !h_busy && !flush;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == CNTW'(DEPTH));
      in_ready[i] = !full[i] && !flush;
      push[i]     = in_valid[i] && in_ready[i];
      // reserved op is consumed but never occupies a slot
      store[i]    = push[i] && (in_op[2*i +: 2] != 2'b11);
      count_n[i]  = count[i] + CNTW'(store[i]) - CNTW'(grant[i]);
    end
  end

  // Round-robin: first non-empty channel at or after the pointer, then wrap.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    rr_ptr_n = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && nonempty[i] && (i >= int'(rr_ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && nonempty[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
    if (!issue_en) grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) rr_ptr_n = (i == NUM_CH-1) ? '0 : RW'(i+1);
    end
    if (flush) rr_ptr_n = '0;
  end

  always_comb begin
    h_op_valid  = 1'b0;
    h_op        = 2'b00;
    h_var       = '0;
    h_val       = 1'b0;
    h_decay     = 1'b0;
    ser_issue   = 1'b0;
    decay_issue = 1'b0;
    if (|grant) begin
      h_op_valid = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i]) begin
          h_op  = mem_op[i][rd_ptr[i]];
          h_var = mem_var[i][rd_ptr[i]];
          h_val = mem_val[i][rd_ptr[i]];
        end
      end
    end else if (issue_en && (ser_state == S_EMIT)) begin
      h_op_valid = 1'b1;
      h_op       = 2'b10;
      h_var      = ser_vars[0];
      ser_issue  = 1'b1;
    end else if (issue_en && decay_flag) begin
      h_decay     = 1'b1;
      decay_issue = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (store[i]) begin
        mem_op[i][wr_ptr[i]]  <= in_op[2*i +: 2];
        mem_var[i][wr_ptr[i]] <= in_var[VAR_W*i +: VAR_W];
        mem_val[i][wr_ptr[i]] <= in_val[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (store[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count_n[i];
      end
      rr_ptr <= rr_ptr_n;
    end
  end

  assign bump_ready = (ser_state == S_IDLE) && !flush;
  assign capture    = bump_ready && (bump_count != 4'd0);

  // Captured lanes shift down so lane 0 is always the next bump out.
  always_comb begin
    ser_state_n = ser_state;
    ser_vars_n  = ser_vars;
    ser_left_n  = ser_left;
    case (ser_state)
      S_IDLE: begin
        if (capture) begin
          ser_vars_n  = bump_vars;
          ser_left_n  = (int'(bump_count) > MAX_BUMP) ? CW'(MAX_BUMP) : CW'(bump_count);
          ser_state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (ser_issue) begin
          ser_vars_n = ser_vars >> VAR_W;
          ser_left_n = ser_left - 1'b1;
          if (ser_left == CW'(1)) ser_state_n = S_IDLE;
        end
      end
      default: ser_state_n = S_IDLE;
    endcase
    if (flush) begin
      ser_state_n = S_IDLE;
      ser_left_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_state <= S_IDLE;
      ser_vars  <= '0;
      ser_left  <= '0;
    end else begin
      ser_state <= ser_state_n;
      ser_vars  <= ser_vars_n;
      ser_left  <= ser_left_n;
    end
  end

  // A new pulse in the issuing cycle re-arms the flag for a later decay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      decay_flag <= 1'b0;
    else if (flush) decay_flag <= 1'b0;
    else            decay_flag <= (decay_flag && !decay_issue) || decay;
  end

  assign pending_ops = (|nonempty) || (ser_state == S_EMIT) || decay_flag || h_busy;

`ifdef VDE_CMDQ_STATS_EN
  logic [CNTW-1:0] peak_n;

  always_comb begin
    peak_n = stat_hwm;
    for (int i = 0; i < NUM_CH; i++) begin
      if (count_n[i] > peak_n) peak_n = count_n[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued <= '0;
      stat_hwm    <= '0;
    end else begin
      if (h_op_valid || h_decay) stat_issued <= stat_issued + 32'd1;
      stat_hwm <= peak_n;
    end
  end
`else
  assign stat_issued = '0;
  assign stat_hwm    = '0;
`endif

endmodule

// File: tb/tb_vde_cmd_queue.sv
// Self-checking bench for vde_cmd_queue: directed scenarios plus a randomized run
// against a queue-based reference model.

module tb_vde_cmd_queue;

  localparam int NUM_CH   = 2;
  localparam int DEPTH    = 4;
  localparam int VAR_W    = 16;
  localparam int MAX_BUMP = 8;
  localparam int HW       = $clog2(DEPTH+1);
`ifdef VDE_CMDQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                       clk, reset, flush;
  logic [NUM_CH-1:0]          in_valid, in_ready, in_val;
  logic [2*NUM_CH-1:0]        in_op;
  logic [VAR_W*NUM_CH-1:0]    in_var;
  logic [3:0]                 bump_count;
  logic [VAR_W*MAX_BUMP-1:0]  bump_vars;
  logic                       bump_ready, decay, h_busy;
  logic                       h_op_valid, h_val, h_decay, pending_ops;
  logic [1:0]                 h_op;
  logic [VAR_W-1:0]           h_var;
  logic [31:0]                stat_issued;
  logic [HW-1:0]              stat_hwm;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]       op;
    logic [VAR_W-1:0] v;
    logic             val;
  } ent_t;

  ent_t             mq[NUM_CH][$];
  logic [VAR_W-1:0] mbq[$];
  int               m_rr;
  bit               m_dflag;
  int               m_issued;
  int               m_hwm;

  vde_cmd_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .VAR_W(VAR_W), .MAX_BUMP(MAX_BUMP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_var(in_var), .in_val(in_val),
    .bump_count(bump_count), .bump_vars(bump_vars), .bump_ready(bump_ready),
    .decay(decay), .h_busy(h_busy),
    .h_op_valid(h_op_valid), .h_op(h_op), .h_var(h_var), .h_val(h_val), .h_decay(h_decay),
    .pending_ops(pending_ops), .stat_issued(stat_issued), .stat_hwm(stat_hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_in();
    flush = 0; in_valid = '0; in_op = '0; in_var = '0; in_val = '0;
    bump_count = '0; bump_vars = '0; decay = 0; h_busy = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
    mbq.delete();
    m_rr = 0;
    m_dflag = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_clear();
    m_issued = 0;
    m_hwm = 0;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1; h_busy = 1;
    @(negedge clk); #1;
    n_cmp++; if (h_op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", h_op_valid); end
    n_cmp++; if (h_decay !== 1'b0) begin n_fail++; $display("FAIL reset_decay got %b want 0", h_decay); end
    n_cmp++; if (pending_ops !== 1'b1) begin n_fail++; $display("FAIL reset_pending_busy got %b want 1", pending_ops); end
    n_cmp++; if (bump_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bump_ready got %b want 1", bump_ready); end
    n_cmp++; if (in_ready !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready got %b want 11", in_ready); end
    h_busy = 0; #1;
    n_cmp++; if (pending_ops !== 1'b0) begin n_fail++; $display("FAIL reset_pending_idle got %b want 0", pending_ops); end
    n_cmp++; if (stat_issued !== 32'd0) begin n_fail++; $display("FAIL reset_stat_issued got %0d want 0", stat_issued); end
    n_cmp++; if (stat_hwm !== '0) begin n_fail++; $display("FAIL reset_stat_hwm got %0d want 0", stat_hwm); end
    @(negedge clk); reset = 0;
    @(negedge clk); #1;
    n_cmp++; if (in_ready !== 2'b11 || bump_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release got in_ready=%b bump_ready=%b want 11/1", in_ready, bump_ready); end
  endtask

  task automatic test_two_channel();
    do_reset();
    in_valid = 2'b11; in_op = {2'b01, 2'b00}; in_var = {16'd9, 16'd5}; in_val = 2'b01;
    #1;
    n_cmp++; if (h_op_valid !== 1'b0) begin n_fail++; $display("FAIL two_ch_no_fallthrough got %b want 0", h_op_valid); end
    @(negedge clk); idle_in(); #1;
    n_cmp++; if ({h_op_valid, h_op, h_var, h_val} !== {1'b1, 2'b00, 16'd5, 1'b1}) begin
      n_fail++; $display("FAIL two_ch_first got v=%b op=%b var=%0d val=%b want 1/00/5/1", h_op_valid, h_op, h_var, h_val); end
    @(negedge clk); #1;
    n_cmp++; if ({h_op_valid, h_op, h_var} !== {1'b1, 2'b01, 16'd9}) begin
      n_fail++; $display("FAIL two_ch_second got v=%b op=%b var=%0d want 1/01/9", h_op_valid, h_op, h_var); end
    @(negedge clk); #1;
    n_cmp++; if (h_op_valid !== 1'b0) begin n_fail++; $display("FAIL two_ch_drained got %b want 0", h_op_valid); end
    n_cmp++; if (stat_issued !== (STATS ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL two_ch_stat_issued got %0d want %0d", stat_issued, STATS ? 2 : 0); end
  endtask

  task automatic test_full();
    do_reset();
    h_busy = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 2'b01; in_op = '0; in_var = '0; in_var[VAR_W-1:0] = VAR_W'(k+1);
      #1;
      n_cmp++; if (in_ready[0] !== (k < 4)) begin n_fail++; $display("FAIL full_ready_%0d got %b want %b", k, in_ready[0], k < 4); end
      @(negedge clk);
    end
    in_valid = '0; #1;
    n_cmp++; if (in_ready[0] !== 1'b0 || pending_ops !== 1'b1) begin n_fail++; $display("FAIL full_held got ready=%b pend=%b want 0/1", in_ready[0], pending_ops); end
    n_cmp++; if (stat_hwm !== (STATS ? HW'(4) : HW'(0))) begin n_fail++; $display("FAIL full_hwm got %0d want %0d", stat_hwm, STATS ? 4 : 0); end
    h_busy = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (h_op_valid !== 1'b1 || h_var !== VAR_W'(k+1)) begin n_fail++; $display("FAIL full_drain_%0d got v=%b var=%0d want 1/%0d", k, h_op_valid, h_var, k+1); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (h_op_valid !== 1'b0 || in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_empty got v=%b ready=%b want 0/1", h_op_valid, in_ready[0]); end
  endtask

  task automatic test_bump_decay();
    logic [VAR_W-1:0] exp_v [3];
    exp_v[0] = 16'd7; exp_v[1] = 16'd8; exp_v[2] = 16'd9;
    do_reset();
    bump_count = 4'd3; bump_vars = '1;
    for (int l = 0; l < 3; l++) bump_vars[l*VAR_W +: VAR_W] = exp_v[l];
    decay = 1; #1;
    n_cmp++; if (bump_ready !== 1'b1 || h_op_valid !== 1'b0) begin n_fail++; $display("FAIL bump_pre got ready=%b v=%b want 1/0", bump_ready, h_op_valid); end
    @(negedge clk); bump_count = '0; decay = 1;
    for (int l = 0; l < 3; l++) begin
      #1;
      n_cmp++; if ({h_op_valid, h_op, h_var, h_decay, bump_ready} !== {1'b1, 2'b10, exp_v[l], 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bump_lane_%0d got v=%b op=%b var=%0d dec=%b rdy=%b want 1/10/%0d/0/0", l, h_op_valid, h_op, h_var, h_decay, bump_ready, exp_v[l]); end
      @(negedge clk); decay = 0;
    end
    #1;
    n_cmp++; if ({h_decay, h_op_valid, bump_ready} !== 3'b101) begin n_fail++; $display("FAIL bump_decay got dec=%b v=%b rdy=%b want 1/0/1", h_decay, h_op_valid, bump_ready); end
    @(negedge clk); #1;
    n_cmp++; if ({h_decay, pending_ops} !== 2'b00) begin n_fail++; $display("FAIL bump_decay_once got dec=%b pend=%b want 0/0", h_decay, pending_ops); end
  endtask

  task automatic test_bump_clip();
    int cnt;
    do_reset();
    bump_count = 4'd12;
    for (int l = 0; l < MAX_BUMP; l++) bump_vars[l*VAR_W +: VAR_W] = VAR_W'(200 + l);
    @(negedge clk);
    bump_count = 4'd3;
    for (int l = 0; l < MAX_BUMP; l++) bump_vars[l*VAR_W +: VAR_W] = 16'h0bad;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (h_op_valid) begin
        n_cmp++; if (h_op !== 2'b10 || h_var !== VAR_W'(200 + cnt)) begin n_fail++; $display("FAIL clip_lane_%0d got op=%b var=%0d want 10/%0d", cnt, h_op, h_var, 200 + cnt); end
        cnt++;
      end
      if (c == 3) bump_count = '0;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (cnt !== 8) begin n_fail++; $display("FAIL clip_count got %0d want 8", cnt); end
    n_cmp++; if (bump_ready !== 1'b1) begin n_fail++; $display("FAIL clip_ready got %b want 1", bump_ready); end
  endtask

  task automatic test_flush();
    do_reset();
    h_busy = 1;
    in_valid = 2'b11; in_op = '0; in_var = {16'd3, 16'd1}; in_val = 2'b00;
    bump_count = 4'd2; bump_vars = '0; bump_vars[VAR_W-1:0] = 16'd44; decay = 1;
    @(negedge clk);
    idle_in(); h_busy = 1;
    in_valid = 2'b01; in_var = {16'd0, 16'd2};
    @(negedge clk);
    in_valid = '0; #1;
    n_cmp++; if (pending_ops !== 1'b1 || bump_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre got pend=%b rdy=%b want 1/0", pending_ops, bump_ready); end
    flush = 1; h_busy = 0; #1;
    n_cmp++; if ({h_op_valid, h_decay, in_ready, bump_ready} !== 5'b00000) begin
      n_fail++; $display("FAIL flush_cycle got v=%b dec=%b rdy=%b brdy=%b want 0/0/00/0", h_op_valid, h_decay, in_ready, bump_ready); end
    @(negedge clk); flush = 0; #1;
    n_cmp++; if ({pending_ops, h_op_valid, h_decay} !== 3'b000) begin
      n_fail++; $display("FAIL flush_after got pend=%b v=%b dec=%b want 0/0/0", pending_ops, h_op_valid, h_decay); end
    n_cmp++; if (in_ready !== 2'b11 || bump_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b/%b want 11/1", in_ready, bump_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bump_count = 4'd5;
    for (int l = 0; l < MAX_BUMP; l++) bump_vars[l*VAR_W +: VAR_W] = VAR_W'(60 + l);
    decay = 1;
    @(negedge clk); bump_count = '0; decay = 0;
    @(negedge clk); #1;
    n_cmp++; if (h_op_valid !== 1'b1 || h_var !== 16'd61) begin n_fail++; $display("FAIL mid_progress got v=%b var=%0d want 1/61", h_op_valid, h_var); end
    #2 reset = 1; #1;
    n_cmp++; if ({h_op_valid, h_decay, pending_ops, bump_ready, in_ready} !== 6'b000111) begin
      n_fail++; $display("FAIL mid_reset got v=%b dec=%b pend=%b brdy=%b rdy=%b want 0/0/0/1/11", h_op_valid, h_decay, pending_ops, bump_ready, in_ready); end
    n_cmp++; if (stat_issued !== 32'd0) begin n_fail++; $display("FAIL mid_reset_stat got %0d want 0", stat_issued); end
    @(negedge clk); reset = 0;
    @(negedge clk); #1;
    n_cmp++; if ({h_op_valid, bump_ready, in_ready} !== 4'b0111) begin
      n_fail++; $display("FAIL mid_release got v=%b brdy=%b rdy=%b want 0/1/11", h_op_valid, bump_ready, in_ready); end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] e_rdy;
    logic              e_brdy, ie, e_valid, e_dec, e_pend, e_val;
    logic [1:0]        e_op;
    logic [VAR_W-1:0]  e_var;
    int                g, c, nb;
    ent_t              e;
    logic [VAR_W-1:0]  tv;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      h_busy = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 99) == 0);
      in_valid = NUM_CH'($urandom);
      if ((cyc % 500) >= 250) in_valid = in_valid & NUM_CH'($urandom);
      in_op  = (2*NUM_CH)'($urandom);
      in_var = (VAR_W*NUM_CH)'($urandom);
      in_val = NUM_CH'($urandom);
      bump_count = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      for (int l = 0; l < MAX_BUMP; l++) bump_vars[l*VAR_W +: VAR_W] = VAR_W'($urandom);
      decay = ($urandom_range(0, 19) == 0);
      #1;
      for (int i = 0; i < NUM_CH; i++) e_rdy[i] = (mq[i].size() < DEPTH) && !flush;
      e_brdy = (mbq.size() == 0) && !flush;
      ie = !h_busy && !flush;
      g = -1;
      if (ie) begin
        for (int j = 0; j < NUM_CH; j++) begin
          c = (m_rr + j) % NUM_CH;
          if (g < 0 && mq[c].size() > 0) g = c;
        end
      end
      e_valid = 0; e_dec = 0; e_op = '0; e_var = '0; e_val = 0;
      if (g >= 0) begin
        e_valid = 1; e_op = mq[g][0].op; e_var = mq[g][0].v; e_val = mq[g][0].val;
      end else if (ie && mbq.size() > 0) begin
        e_valid = 1; e_op = 2'b10; e_var = mbq[0];
      end else if (ie && m_dflag) begin
        e_dec = 1;
      end
      e_pend = h_busy || m_dflag || (mbq.size() > 0);
      for (int i = 0; i < NUM_CH; i++) if (mq[i].size() > 0) e_pend = 1;

      n_cmp++; if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, e_rdy); end
      n_cmp++; if (bump_ready !== e_brdy) begin n_fail++; $display("FAIL rnd_bump_ready cyc %0d got %b want %b", cyc, bump_ready, e_brdy); end
      n_cmp++; if (h_op_valid !== e_valid || h_decay !== e_dec) begin n_fail++; $display("FAIL rnd_issue cyc %0d got v=%b dec=%b want %b/%b", cyc, h_op_valid, h_decay, e_valid, e_dec); end
      n_cmp++; if (pending_ops !== e_pend) begin n_fail++; $display("FAIL rnd_pending cyc %0d got %b want %b", cyc, pending_ops, e_pend); end
      if (e_valid) begin
        n_cmp++; if (h_op !== e_op || h_var !== e_var || h_val !== e_val) begin
          n_fail++; $display("FAIL rnd_payload cyc %0d got %b/%0d/%b want %b/%0d/%b", cyc, h_op, h_var, h_val, e_op, e_var, e_val); end
      end
      if ((cyc % 100) == 99) begin
        n_cmp++; if (stat_issued !== (STATS ? 32'(m_issued) : 32'd0)) begin n_fail++; $display("FAIL rnd_stat_issued cyc %0d got %0d want %0d", cyc, stat_issued, STATS ? m_issued : 0); end
        n_cmp++; if (stat_hwm !== (STATS ? HW'(m_hwm) : HW'(0))) begin n_fail++; $display("FAIL rnd_stat_hwm cyc %0d got %0d want %0d", cyc, stat_hwm, STATS ? m_hwm : 0); end
      end

      if (flush) begin
        model_clear();
      end else begin
        if (g >= 0) begin
          e = mq[g].pop_front();
          m_rr = (g + 1) % NUM_CH;
          m_issued++;
        end else if (ie && mbq.size() > 0) begin
          tv = mbq.pop_front();
          m_issued++;
        end else if (ie && m_dflag) begin
          m_dflag = 0;
          m_issued++;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (in_valid[i] && e_rdy[i] && in_op[2*i +: 2] != 2'b11) begin
            e.op = in_op[2*i +: 2]; e.v = in_var[VAR_W*i +: VAR_W]; e.val = in_val[i];
            mq[i].push_back(e);
          end
        end
        if (e_brdy && bump_count != 0) begin
          nb = (int'(bump_count) > MAX_BUMP) ? MAX_BUMP : int'(bump_count);
          for (int l = 0; l < nb; l++) mbq.push_back(bump_vars[l*VAR_W +: VAR_W]);
        end
        if (decay) m_dflag = 1;
      end
      for (int i = 0; i < NUM_CH; i++) if (mq[i].size() > m_hwm) m_hwm = mq[i].size();
      @(negedge clk);
    end
    idle_in();
  endtask

  initial begin
    reset = 1;
    idle_in();
    test_reset();
    test_two_channel();
    test_full();
    test_bump_decay();
    test_bump_clip();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
